// File: rtl/riscv_defines.sv
// Shared widths, FSM encoding and request payload for the interrupt arbiter.
package riscv_defines;

    localparam int unsigned IRQ_LEV_W = 8;
    localparam int unsigned IRQ_ID_W  = 10;

    typedef enum logic [1:0] {
        IRQ_ARB_IDLE    = 2'd0,
        IRQ_ARB_OFFER   = 2'd1,
        IRQ_ARB_HOLDOFF = 2'd2
    } irq_arb_state_t;

    // Request as presented to the core interrupt controller.
    typedef struct packed {
        logic                 pending;
        logic [IRQ_LEV_W-1:0] lev;
        logic                 sec;
        logic [IRQ_ID_W-1:0]  id;
    } irq_req_t;

endpackage

// File: rtl/riscv_irq_arbiter_max_sel.sv
// Combinational selector: highest level among eligible lines, ties broken by
// the first index at or above rr_ptr (wrapping at NUM_IRQ-1).
module riscv_irq_max_sel
    import riscv_defines::*;
#(
    parameter int unsigned NUM_IRQ = 32,
    parameter int unsigned IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]   elig,
    input  logic [IRQ_LEV_W-1:0] lev [NUM_IRQ],
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 found_c,
    output logic [IDX_W-1:0]     win_idx_c,
    output logic [IRQ_LEV_W-1:0] win_lev_c
);

    logic [IRQ_LEV_W-1:0] max_lev;
    logic                 any_elig;
    logic                 hit;

    // Pass 1: maximum level over all eligible lines.
    always_comb begin
        max_lev  = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (elig[IDX_W'(i)] && (lev[IDX_W'(i)] >= max_lev)) begin
                max_lev  = lev[IDX_W'(i)];
                any_elig = 1'b1;
            end
        end
    end

    // Pass 2: first candidate at max level scanning upward from rr_ptr.
    always_comb begin
        int unsigned idx;
        hit       = 1'b0;
        win_idx_c = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_IRQ) begin
                idx = idx - NUM_IRQ;
            end
            if (!hit && elig[IDX_W'(idx)] && (lev[IDX_W'(idx)] == max_lev)) begin
                hit       = 1'b1;
                win_idx_c = IDX_W'(idx);
            end
        end
    end

    assign found_c   = any_elig & hit;
    assign win_lev_c = max_lev;

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: tracks per-line pending state and levels, offers the
// single best eligible line to the core interrupt controller and retires it
// on acknowledge.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned          NUM_IRQ   = 32,
    parameter logic [IRQ_LEV_W-1:0] LEV_RESET = 8'd1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IRQ-1:0]           irq_i,
    input  logic [NUM_IRQ-1:0]           irq_edge_cfg_i,
    input  logic [NUM_IRQ-1:0]           irq_en_i,
    input  logic [NUM_IRQ-1:0]           irq_sec_cfg_i,
    input  logic                         cfg_lev_we_i,
    input  logic [$clog2(NUM_IRQ)-1:0]   cfg_lev_idx_i,
    input  logic [IRQ_LEV_W-1:0]         cfg_lev_wdata_i,
    output logic                         irq_pending_o,
    output logic [IRQ_LEV_W-1:0]         irq_lev_o,
    output logic                         irq_sec_o,
    output logic [IRQ_ID_W-1:0]          irq_id_o,
    input  logic                         irq_ack_i,
    input  logic [IRQ_ID_W-1:0]          irq_ack_id_i
);

    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0]   irq_q;
    logic [NUM_IRQ-1:0]   pend;
    logic [NUM_IRQ-1:0]   pend_d;
    logic [NUM_IRQ-1:0]   elig;
    logic [IRQ_LEV_W-1:0] lev [NUM_IRQ];
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_ptr_d;

    irq_arb_state_t       state;
    irq_arb_state_t       state_d;
    irq_req_t             req_q;
    irq_req_t             req_d;
    irq_req_t             win_req;

    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IRQ_LEV_W-1:0] win_lev;
    logic                 ack_in_range;
    logic [IDX_W-1:0]     ack_next_ptr;

    // Next pending state: edge lines set on rising edge (set beats ack-clear),
    // level lines simply follow the input.
    always_comb begin
        pend_d = pend;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge_cfg_i[IDX_W'(i)]) begin
                if (irq_i[IDX_W'(i)] && !irq_q[IDX_W'(i)]) begin
                    pend_d[IDX_W'(i)] = 1'b1;
                end else if (irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(i))) begin
                    pend_d[IDX_W'(i)] = 1'b0;
                end
            end else begin
                pend_d[IDX_W'(i)] = irq_i[IDX_W'(i)];
            end
        end
    end

    // Edge-detect history and pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= '0;
            pend  <= '0;
        end else begin
            irq_q <= irq_i;
            pend  <= pend_d;
        end
    end

    // Per-line level registers; an index with no matching line writes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                lev[i] <= LEV_RESET;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (cfg_lev_we_i && (cfg_lev_idx_i == IDX_W'(i))) begin
                    lev[i] <= cfg_lev_wdata_i;
                end
            end
        end
    end

    assign elig = pend & irq_en_i;

    riscv_irq_max_sel #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_max_sel (
        .elig      (elig),
        .lev       (lev),
        .rr_ptr    (rr_ptr),
        .found_c   (found),
        .win_idx_c (win_idx),
        .win_lev_c (win_lev)
    );

    // Candidate request built from the current winner.
    always_comb begin
        win_req.pending = 1'b1;
        win_req.lev     = win_lev;
        win_req.sec     = irq_sec_cfg_i[win_idx];
        win_req.id      = IRQ_ID_W'(win_idx);
    end

    // Round-robin pointer moves past the acked id; ids beyond the last line are ignored.
    assign ack_in_range = (irq_ack_id_i < IRQ_ID_W'(NUM_IRQ));
    assign ack_next_ptr = (irq_ack_id_i == IRQ_ID_W'(NUM_IRQ - 1)) ? '0
                                                                   : IDX_W'(irq_ack_id_i + 1'b1);

    // Next state, next registered outputs and round-robin pointer.
    always_comb begin
        state_d  = state;
        req_d    = req_q;
        rr_ptr_d = rr_ptr;
        case (state)
            IRQ_ARB_IDLE: begin
                req_d.pending = 1'b0;
                if (found) begin
                    state_d = IRQ_ARB_OFFER;
                    req_d   = win_req;
                end
            end
            IRQ_ARB_OFFER: begin
                if (irq_ack_i) begin
                    state_d       = IRQ_ARB_HOLDOFF;
                    req_d.pending = 1'b0;
                    if (ack_in_range) begin
                        rr_ptr_d = ack_next_ptr;
                    end
                end else if (found) begin
                    req_d = win_req;
                end else begin
                    state_d = IRQ_ARB_IDLE;
                    req_d   = '0;
                end
            end
            IRQ_ARB_HOLDOFF: begin
                state_d       = IRQ_ARB_IDLE;
                req_d.pending = 1'b0;
            end
            default: begin
                state_d = IRQ_ARB_IDLE;
                req_d   = '0;
            end
        endcase
    end

    // FSM state, output request and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IRQ_ARB_IDLE;
            req_q  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            req_q  <= req_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    assign irq_pending_o = req_q.pending;
    assign irq_lev_o     = req_q.lev;
    assign irq_sec_o     = req_q.sec;
    assign irq_id_o      = req_q.id;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Scoreboard bench for riscv_irq_arbiter: directed stimulus pushes expected
// offers (id, level, secure, cycle); a monitor pops them on each new offer.
module tb_riscv_irq_arbiter;

    localparam int N = 32;

    typedef struct {
        int id;
        int lev;
        int sec;
        int at;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] irq;
    logic [31:0] edge_cfg;
    logic [31:0] en;
    logic [31:0] sec_cfg;
    logic        lev_we;
    logic [4:0]  lev_idx;
    logic [7:0]  lev_wdata;
    logic        pend_o;
    logic [7:0]  lev_o;
    logic        sec_o;
    logic [9:0]  id_o;
    logic        ack;
    logic [9:0]  ack_id;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    riscv_irq_arbiter #(
        .NUM_IRQ   (N),
        .LEV_RESET (8'd1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_i           (irq),
        .irq_edge_cfg_i  (edge_cfg),
        .irq_en_i        (en),
        .irq_sec_cfg_i   (sec_cfg),
        .cfg_lev_we_i    (lev_we),
        .cfg_lev_idx_i   (lev_idx),
        .cfg_lev_wdata_i (lev_wdata),
        .irq_pending_o   (pend_o),
        .irq_lev_o       (lev_o),
        .irq_sec_o       (sec_o),
        .irq_id_o        (id_o),
        .irq_ack_i       (ack),
        .irq_ack_id_i    (ack_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    // Monitor: a new offer is pending rising, or the offered line changing.
    int prev_pend = 0;
    int prev_id   = 0;
    int prev_lev  = 0;
    always @(negedge clk) begin
        if (pend_o && (prev_pend == 0 || int'(id_o) != prev_id || int'(lev_o) != prev_lev)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_offer: got id=%0d lev=%0d sec=%0d at cyc=%0d, want no offer",
                         id_o, lev_o, sec_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(id_o) != e.id || int'(lev_o) != e.lev || int'(sec_o) != e.sec || cyc != e.at) begin
                    bad++;
                    $display("FAIL offer: got id=%0d lev=%0d sec=%0d cyc=%0d, want id=%0d lev=%0d sec=%0d cyc=%0d",
                             id_o, lev_o, sec_o, cyc, e.id, e.lev, e.sec, e.at);
                end
            end
        end
        prev_pend = int'(pend_o);
        prev_id   = int'(id_o);
        prev_lev  = int'(lev_o);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic exp_offer(input int id, input int lv, input int dly);
        exp_t e;
        e.id  = id;
        e.lev = lv;
        e.sec = int'(sec_cfg[id]);
        e.at  = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic write_lev(input int idx, input int v);
        lev_we    = 1'b1;
        lev_idx   = 5'(idx);
        lev_wdata = 8'(v);
        step(1);
        lev_we    = 1'b0;
    endtask

    task automatic ack_drive(input int id);
        ack    = 1'b1;
        ack_id = 10'(id);
    endtask

    // Ack, then wait out HOLDOFF and IDLE: returns on the cycle a re-offer appears.
    task automatic ack_cycle(input int id);
        ack_drive(id);
        step(1);
        ack = 1'b0;
        step(2);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pend"}, int'(pend_o), 0);
        chk({nm, "_id"},   int'(id_o),   0);
        chk({nm, "_lev"},  int'(lev_o),  0);
        chk({nm, "_sec"},  int'(sec_o),  0);
    endtask

    initial begin
        rst       = 1'b1;
        irq       = '0;
        edge_cfg  = 32'hFFFF_FEFF;
        en        = '1;
        sec_cfg   = 32'h0000_02A0;
        lev_we    = 1'b0;
        lev_idx   = '0;
        lev_wdata = '0;
        ack       = 1'b0;
        ack_id    = '0;

        step(3);
        chk_zero("reset");
        rst = 1'b0;
        step(2);

        // Single edge line, ack, holdoff then idle.
        irq[5] = 1'b1; exp_offer(5, 1, 2); step(1);
        irq[5] = 1'b0; step(1);
        ack_drive(5); step(1); ack = 1'b0;
        chk("holdoff_pend", int'(pend_o), 0);
        chk("holdoff_id",   int'(id_o),   5);
        chk("holdoff_lev",  int'(lev_o),  1);
        step(2);
        chk("t1_idle", int'(pend_o), 0);

        // Highest level wins; higher-level arrival replaces the offer.
        write_lev(3, 4); write_lev(7, 9);
        irq[3] = 1'b1; irq[7] = 1'b1; exp_offer(7, 9, 2); step(1);
        irq[3] = 1'b0; irq[7] = 1'b0; step(1);
        lev_we = 1'b1; lev_idx = 5'd2; lev_wdata = 8'd12; irq[2] = 1'b1;
        exp_offer(2, 12, 2); step(1);
        lev_we = 1'b0; irq[2] = 1'b0;
        chk("still_7", int'(id_o), 7);
        step(1);
        exp_offer(7, 9, 3); ack_cycle(2);
        exp_offer(3, 4, 3); ack_cycle(7);
        ack_cycle(3);
        chk("t2_idle", int'(pend_o), 0);

        rst = 1'b1; step(1); rst = 1'b0; step(1);

        // Round-robin among equal levels.
        write_lev(1, 3); write_lev(4, 3); write_lev(6, 3); write_lev(9, 3);
        irq[1] = 1'b1; irq[4] = 1'b1; irq[6] = 1'b1; exp_offer(1, 3, 2); step(1);
        irq = '0; step(1);
        exp_offer(4, 3, 3); ack_cycle(1);
        exp_offer(6, 3, 3); ack_cycle(4);
        ack_cycle(6);
        step(1);
        chk("t3_idle", int'(pend_o), 0);
        // rr_ptr is 7: 9 first, then wrap to 1, then 6.
        irq[1] = 1'b1; irq[6] = 1'b1; irq[9] = 1'b1; exp_offer(9, 3, 2); step(1);
        irq = '0; step(1);
        exp_offer(1, 3, 3); ack_cycle(9);
        exp_offer(6, 3, 3); ack_cycle(1);
        ack_cycle(6);
        step(1);

        // Level line withdrawn before ack.
        irq[8] = 1'b1; exp_offer(8, 1, 2); step(2);
        irq[8] = 1'b0; step(2);
        chk_zero("withdrawn");
        // Level line acked while still high is re-offered.
        irq[8] = 1'b1; exp_offer(8, 1, 2); step(2);
        exp_offer(8, 1, 3); ack_cycle(8);
        irq[8] = 1'b0; ack_drive(8); step(1); ack = 1'b0; step(3);
        chk("t4_idle", int'(pend_o), 0);

        // Re-edge in the same cycle as its ack keeps the line pending.
        irq[9] = 1'b1; exp_offer(9, 3, 2); step(1);
        irq[9] = 1'b0; step(1);
        irq[9] = 1'b1; exp_offer(9, 3, 3); ack_drive(9); step(1);
        irq[9] = 1'b0; ack = 1'b0; step(2);
        ack_cycle(9);
        step(1);
        chk("t5_idle", int'(pend_o), 0);

        // Out-of-range ack id: holdoff taken, nothing cleared, rr_ptr stays 10.
        irq[1] = 1'b1; irq[9] = 1'b1; exp_offer(1, 3, 2); step(1);
        irq = '0; step(1);
        exp_offer(1, 3, 3); ack_drive(40); step(1); ack = 1'b0;
        chk("ack40_holdoff", int'(pend_o), 0);
        step(2);
        exp_offer(9, 3, 3); ack_cycle(1);
        ack_cycle(9);
        step(1);

        // Masked edge line keeps pending, offered once enabled.
        en[5] = 1'b0; irq[5] = 1'b1; step(1);
        irq[5] = 1'b0; step(4);
        chk("masked", int'(pend_o), 0);
        en[5] = 1'b1; exp_offer(5, 1, 1); step(2);

        // Asynchronous reset mid-offer.
        rst = 1'b1; #1;
        chk_zero("async_rst");
        step(1); rst = 1'b0; step(1);
        // Level back to 1 and line 5 not replayed.
        irq[9] = 1'b1; exp_offer(9, 1, 2); step(1);
        irq[9] = 1'b0; step(1);
        ack_cycle(9);
        step(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
